// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight, buffers responses for decode.
// Optional macro IFETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        imem_need,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];

  logic          pending;
  logic          issue;
  logic          resp_hit;
  logic          bypass;
  logic          head_valid;
  logic          push;
  logic          buf_pop;
  logic [31:0]   redirect_pc_al;
  logic          unused_redirect_lsb;

  assign redirect_pc_al      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    pending  = (state_q != ST_ISSUE);
    // Issue is gated by occupancy plus in-flight request so the buffer can never overflow.
    issue    = rst && (state_q == ST_ISSUE) && ((count_q + CW'(pending)) < DEPTH_C);
    resp_hit = (state_q == ST_WAIT) && imem_resp;
`ifdef IFETCH_BYPASS_EN
    bypass   = resp_hit && !redirect_valid && (count_q == '0);
`else
    bypass   = 1'b0;
`endif
    head_valid = (count_q != '0) || bypass;
    buf_pop    = go && (count_q != '0) && !redirect_valid;
    push       = resp_hit && !redirect_valid && !(bypass && go);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    case (state_q)
      ST_ISSUE: begin
        if (issue) begin
          state_d    = ST_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      ST_WAIT:    if (imem_resp) state_d = ST_ISSUE;
      ST_DISCARD: if (imem_resp) state_d = ST_ISSUE;
      default:    state_d = ST_ISSUE;
    endcase

    if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
    if (buf_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(buf_pop);

    // A redirect flushes everything; a request still in flight becomes stale and its response is dropped.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_al;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if (issue || ((state_q != ST_ISSUE) && !imem_resp)) state_d = ST_DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
      buf_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_rmask = issue ? 4'hF : 4'h0;
    imem_addr  = issue ? fetch_pc_q : 32'h0;
    imem_need  = rst && (issue || pending);
    if_valid   = rst && head_valid;
    if_pc      = 32'h0;
    if_inst    = 32'h0;
    if (rst && bypass) begin
      if_pc   = req_pc_q;
      if_inst = imem_rdata;
    end else if (rst && (count_q != '0)) begin
      if_pc   = buf_pc_q[rd_ptr_q];
      if_inst = buf_inst_q[rd_ptr_q];
    end
    if_pc_next = if_valid ? (if_pc + 32'd4) : 32'h0;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: per-cycle vector table, directed corner sequences and a random phase,
// all checked against a transaction-level model with a scoreboard queue of expected fetches.
`timescale 1ns/1ps
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          DEPTH    = 2;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_need;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc_next;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .go(go),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .imem_need(imem_need),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_pc_next(if_pc_next)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {bit go; bit resp; logic [3:0] rmask; logic [31:0] addr; bit need;} vec_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          m_out, m_stale;
  logic [31:0] m_fpc, m_req;
  vec_t        vecs[8];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0;
    m_stale = 1'b0;
    m_fpc = RESET_PC;
    m_req = 32'h0;
    sb.delete();
  endtask

  // Drive one cycle's inputs, sample at the falling edge, check against the model and advance it.
  task automatic cyc_begin(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    bit   issue_e, accept, empty0, valid_e;
    ent_t head;
    go = g;
    imem_resp = r;
    redirect_valid = rd;
    redirect_pc = rpc;
    imem_rdata = r ? mem_data(m_req) : $urandom;
    @(negedge clk);
    issue_e = !m_out && (sb.size() < DEPTH);
    accept  = r && m_out && !m_stale && !rd;
    empty0  = (sb.size() == 0);
    valid_e = !empty0 || (BYP && accept);
    check("m_rmask", 32'(imem_rmask), issue_e ? 32'hF : 32'h0);
    check("m_addr", imem_addr, issue_e ? m_fpc : 32'h0);
    check("m_need", 32'(imem_need), 32'(issue_e || m_out));
    check("m_valid", 32'(if_valid), 32'(valid_e));
    if (valid_e) begin
      if (empty0) begin
        head.pc = m_req;
        head.inst = mem_data(m_req);
      end else begin
        head = sb[0];
      end
      check("sb_pc", if_pc, head.pc);
      check("sb_inst", if_inst, head.inst);
      check("sb_pc_next", if_pc_next, head.pc + 32'd4);
    end
    if (rd) begin
      sb.delete();
      if (issue_e) begin
        m_out = 1'b1; m_stale = 1'b1; m_req = m_fpc;
      end else if (m_out && r) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      if (g && !empty0) void'(sb.pop_front());
      if (accept && !(BYP && empty0 && g)) begin
        head.pc = m_req;
        head.inst = mem_data(m_req);
        sb.push_back(head);
      end
      if (issue_e) begin
        m_out = 1'b1; m_stale = 1'b0; m_req = m_fpc; m_fpc = m_fpc + 32'd4;
      end else if (m_out && r) begin
        m_out = 1'b0; m_stale = 1'b0;
      end
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    cyc_begin(g, r, rd, rpc);
    cyc_end();
  endtask

  task automatic do_reset(input bit r_during);
    rst = 1'b0;
    go = 1'b1;
    redirect_valid = 1'b0;
    imem_resp = r_during;
    imem_rdata = $urandom;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rmask", 32'(imem_rmask), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_need", 32'(imem_need), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc_next", if_pc_next, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    imem_resp = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'hF, 32'h1eceb000, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'h0, 32'h00000000, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h1eceb004, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h00000000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h1eceb008, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'h0, 32'h00000000, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h1eceb00c, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'h0, 32'h00000000, 1'b1};
    model_reset();

    // Streaming fetch, response one cycle after each request
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc_begin(vecs[i].go, vecs[i].resp, 1'b0, 32'h0);
      check("vec_rmask", 32'(imem_rmask), 32'(vecs[i].rmask));
      check("vec_addr", imem_addr, vecs[i].addr);
      check("vec_need", 32'(imem_need), 32'(vecs[i].need));
      cyc_end();
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // go held low: two entries fill the buffer, then fetch stalls
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc_begin(1'b0, 1'b0, 1'b0, 32'h0);
      check("full_rmask", 32'(imem_rmask), 32'h0);
      check("full_need", 32'(imem_need), 32'h0);
      check("full_valid", 32'(if_valid), 32'h1);
      cyc_end();
    end
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("pop_pc", if_pc, RESET_PC);
    check("pop_rmask", 32'(imem_rmask), 32'h0);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, 32'h0);
    check("refill_rmask", 32'(imem_rmask), 32'hF);
    check("refill_addr", imem_addr, 32'h1eceb008);
    check("refill_head", if_pc, 32'h1eceb004);
    cyc_end();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect while waiting; the late response is discarded
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b0, 1'b1, 32'h1eceb100);
    check("rdw_need", 32'(imem_need), 32'h1);
    cyc_end();
    for (int i = 0; i < 2; i++) begin
      cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
      check("disc_valid", 32'(if_valid), 32'h0);
      check("disc_rmask", 32'(imem_rmask), 32'h0);
      cyc_end();
    end
    cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
    check("stale_valid", 32'(if_valid), 32'h0);
    check("stale_need", 32'(imem_need), 32'h1);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("rdw_addr", imem_addr, 32'h1eceb100);
    check("rdw_rmask", 32'(imem_rmask), 32'hF);
    check("rdw_valid", 32'(if_valid), 32'h0);
    cyc_end();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect coincident with the response
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b1, 1'b1, 32'h1eceb200);
    check("co_valid", 32'(if_valid), 32'h0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("co_rmask", 32'(imem_rmask), 32'hF);
    check("co_addr", imem_addr, 32'h1eceb200);
    check("co_valid2", 32'(if_valid), 32'h0);
    cyc_end();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect with a full buffer and go high, misaligned target
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b0, 1'b1, 32'h1eceb102);
    check("fl_valid_pre", 32'(if_valid), 32'h1);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 1'b0, 32'h0);
    check("fl_valid", 32'(if_valid), 32'h0);
    check("fl_rmask", 32'(imem_rmask), 32'hF);
    check("fl_addr", imem_addr, 32'h1eceb100);
    cyc_end();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("fl_head", if_pc, 32'h1eceb100);
    check("fl_inst", if_inst, mem_data(32'h1eceb100));
    cyc_end();

    // Reset while waiting, response arrives during reset
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset(1'b1);
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("post_rst_addr", imem_addr, RESET_PC);
    check("post_rst_valid", 32'(if_valid), 32'h0);
    cyc_end();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap at 2^32
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hfffffff8);
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_a0", imem_addr, 32'hfffffff8);
    cyc_end();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_a1", imem_addr, 32'hfffffffc);
    cyc_end();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_a2", imem_addr, 32'h00000000);
    cyc_end();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic: variable latency, go and redirects
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      bit          g, r, rd;
      logic [31:0] rpc;
      g   = ($urandom_range(0, 3) != 0);
      r   = m_out && ($urandom_range(0, 1) == 1);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = 32'h1eceb000 + 32'($urandom_range(0, 1023));
      step(g, r, rd, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
